// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   // Arbiter transaction phases.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   // Requesting port that owns the current transaction.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   // Read data returned when a response times out.
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_timer.sv
// Response timeout counter: counts enabled cycles and flags the last allowed one.
module mem_arb_timer #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned    CntW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Expired during the TIMEOUT_CYC-th enabled cycle; the counter holds there.
   always_comb begin
      expired = en && (cnt_q == CntMax);
      cnt_d   = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store ports onto a
// single-outstanding memory interface, with response timeout and stall counter.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   // Instruction fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   // Load/store port
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [3:0]  ls_wmask,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   // Memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   // Status
   output logic        err,
   output logic [31:0] stall_cnt
);

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   owner_e      last_q, last_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic        we_q, we_d;
   logic [31:0] stall_q, stall_d;

   logic        grant_if;
   logic        done;
   logic        abort;
   logic        tmr_expired;
   logic [31:0] rsp_data;

   mem_arb_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != RESP),
      .en      (state_q == RESP),
      .expired (tmr_expired)
   );

   // Next-state, capture of the granted request and per-state control.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      we_d     = we_q;
      if_gnt   = 1'b0;
      ls_gnt   = 1'b0;
      mem_req  = 1'b0;
      done     = 1'b0;
      abort    = 1'b0;
      // IF wins unless LS is also requesting and IF was the last owner.
      grant_if = if_req && (!ls_req || (last_q == OWN_LS));

      unique case (state_q)
         IDLE: begin
            // Gate on rst so no grant escapes while reset is held.
            if ((if_req || ls_req) && !rst) begin
               state_d = REQ;
               if (grant_if) begin
                  if_gnt  = 1'b1;
                  owner_d = OWN_IF;
                  last_d  = OWN_IF;
                  addr_d  = if_addr;
                  wdata_d = '0;
                  wmask_d = '0;
                  we_d    = 1'b0;
               end else begin
                  ls_gnt  = 1'b1;
                  owner_d = OWN_LS;
                  last_d  = OWN_LS;
                  addr_d  = ls_addr;
                  wdata_d = ls_wdata;
                  wmask_d = ls_wmask;
                  we_d    = ls_we;
               end
            end
         end
         REQ: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            // A real response takes priority over a same-cycle timeout.
            if (mem_rvalid) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (tmr_expired) begin
               done    = 1'b1;
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Saturating count of cycles where memory back-pressures a request.
   always_comb begin
      stall_d = stall_q;
      if ((state_q == REQ) && !mem_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // Response routing to the owning port; non-owner outputs stay at zero.
   always_comb begin
      rsp_data  = abort ? ERR_DATA : mem_rdata;
      if_rvalid = done && (owner_q == OWN_IF);
      ls_rvalid = done && (owner_q == OWN_LS);
      if_rdata  = if_rvalid ? rsp_data : 32'd0;
      ls_rdata  = ls_rvalid ? rsp_data : 32'd0;
      err       = abort;
      mem_we    = mem_req && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_wmask = wmask_q;
      stall_cnt = stall_q;
   end

   // State and latched-field registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWN_IF;
         last_q  <= OWN_LS;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         we_q    <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         we_q    <= we_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        ls_req, ls_we, ls_gnt, ls_rvalid;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic [3:0]  ls_wmask;
   logic        mem_req, mem_we, mem_ready, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        err;
   logic [31:0] stall_cnt;

   typedef struct {
      logic        is_ls;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   logic s2_ls;

   always #5 clk = ~clk;

   mem_arbiter #(
      .TIMEOUT_CYC (16),
      .ERR_DATA    (32'hDEADBEEF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .ls_req     (ls_req),
      .ls_we      (ls_we),
      .ls_addr    (ls_addr),
      .ls_wdata   (ls_wdata),
      .ls_wmask   (ls_wmask),
      .ls_gnt     (ls_gnt),
      .ls_rvalid  (ls_rvalid),
      .ls_rdata   (ls_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .err        (err),
      .stall_cnt  (stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Scoreboard: every completion pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (!rst && (if_rvalid || ls_rvalid)) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_unexpected: observed if_rvalid=%b ls_rvalid=%b expected none",
                   if_rvalid, ls_rvalid);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_owner", {30'd0, if_rvalid, ls_rvalid}, mon_e.is_ls ? 32'd1 : 32'd2);
            check("sb_rdata", ls_rvalid ? ls_rdata : if_rdata, mon_e.data);
            check("sb_err", {31'd0, err}, {31'd0, mon_e.err});
         end
      end
   end

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      // Outputs quiet while reset is held, even with requests pending.
      if_req = 1'b1; ls_req = 1'b1;
      if_addr = 32'h0000_1000; ls_addr = 32'h0000_2000;
      smp();
      check("rst_if_gnt", if_gnt, 0);
      check("rst_ls_gnt", ls_gnt, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_stall", stall_cnt, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_err", err, 0);
      tick();
      rst = 1'b0;

      // Both ports held from reset: grants alternate IF, LS, IF, LS.
      for (int i = 0; i < 4; i++) begin
         s2_ls = (i % 2) == 1;
         smp();
         check("s2_if_gnt", if_gnt, !s2_ls);
         check("s2_ls_gnt", ls_gnt, s2_ls);
         sb_q.push_back('{s2_ls, 32'hA000_0000 + i, 1'b0});
         tick();
         mem_ready = 1'b1;
         smp();
         check("s2_mem_req", mem_req, 1);
         check("s2_mem_addr", mem_addr, s2_ls ? 32'h0000_2000 : 32'h0000_1000);
         tick();
         mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + i;
         smp();
         // Requests present in the completion cycle wait for the next IDLE.
         check("s2_no_gnt", {30'd0, if_gnt, ls_gnt}, 0);
         tick();
         mem_rvalid = 1'b0;
      end
      if_req = 1'b0; ls_req = 1'b0;

      // Minimum-latency fetch.
      if_req = 1'b1; if_addr = 32'h8000_0000;
      smp();
      check("s1_if_gnt", if_gnt, 1);
      check("s1_mem_req_t0", mem_req, 0);
      sb_q.push_back('{1'b0, 32'h0010_0073, 1'b0});
      tick();
      if_req = 1'b0; mem_ready = 1'b1;
      smp();
      check("s1_mem_req_t1", mem_req, 1);
      check("s1_mem_addr", mem_addr, 32'h8000_0000);
      check("s1_mem_we", mem_we, 0);
      check("s1_mem_wmask", mem_wmask, 0);
      check("s1_if_rvalid_t1", if_rvalid, 0);
      tick();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0073;
      smp();
      check("s1_if_rvalid_t2", if_rvalid, 1);
      check("s1_mem_req_t2", mem_req, 0);
      tick();
      mem_rvalid = 1'b0;
      smp();
      check("s1_if_rvalid_off", if_rvalid, 0);
      check("s1_if_rdata_off", if_rdata, 0);

      // Store with three back-pressured cycles; inputs change after grant.
      tick();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h8000_0104;
      ls_wdata = 32'h1234_5678; ls_wmask = 4'b0001;
      smp();
      check("s3_ls_gnt", ls_gnt, 1);
      check("s3_if_gnt", if_gnt, 0);
      sb_q.push_back('{1'b1, 32'h0000_0000, 1'b0});
      tick();
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'hFFFF_FFFF;
      ls_wdata = 32'hFFFF_FFFF; ls_wmask = 4'hF; mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) mem_ready = 1'b1;
         smp();
         check("s3_mem_req", mem_req, 1);
         check("s3_mem_we", mem_we, 1);
         check("s3_mem_addr", mem_addr, 32'h8000_0104);
         check("s3_mem_wdata", mem_wdata, 32'h1234_5678);
         check("s3_mem_wmask", mem_wmask, 4'b0001);
         if (k == 3) check("s3_stall", stall_cnt, 3);
         tick();
      end
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
      smp();
      check("s3_ls_rvalid", ls_rvalid, 1);
      check("s3_stall_hold", stall_cnt, 3);
      tick();
      mem_rvalid = 1'b0;

      // Load that never gets a response: abort after the timeout.
      ls_req = 1'b1; ls_addr = 32'h8000_0200;
      smp();
      check("s4_ls_gnt", ls_gnt, 1);
      sb_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b1});
      tick();
      ls_req = 1'b0; mem_ready = 1'b1;
      smp();
      check("s4_mem_req", mem_req, 1);
      tick();
      mem_ready = 1'b0;
      for (int k = 0; k < 15; k++) begin
         smp();
         check("s4_wait_rvalid", ls_rvalid, 0);
         check("s4_wait_err", err, 0);
         tick();
      end
      smp();
      check("s4_to_rvalid", ls_rvalid, 1);
      check("s4_to_err", err, 1);
      check("s4_to_rdata", ls_rdata, 32'hDEAD_BEEF);
      tick();
      // Stray response in IDLE is ignored.
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      smp();
      check("s4_idle_rvalid", {30'd0, if_rvalid, ls_rvalid}, 0);
      check("s4_idle_err", err, 0);
      tick();
      // Next fetch runs normally; a response during REQ is ignored.
      if_req = 1'b1; if_addr = 32'h8000_0010; mem_rvalid = 1'b0;
      smp();
      check("s4_next_gnt", if_gnt, 1);
      sb_q.push_back('{1'b0, 32'h0000_0077, 1'b0});
      tick();
      if_req = 1'b0; mem_rvalid = 1'b1;
      smp();
      check("s4_req_mem_req", mem_req, 1);
      check("s4_req_rvalid", if_rvalid, 0);
      tick();
      mem_rvalid = 1'b0; mem_ready = 1'b1;
      smp();
      tick();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
      smp();
      check("s4_next_rvalid", if_rvalid, 1);
      tick();
      mem_rvalid = 1'b0;

      // Reset in the middle of RESP.
      if_req = 1'b1; if_addr = 32'h8000_0020;
      smp();
      check("s5_gnt", if_gnt, 1);
      tick();
      if_req = 1'b0; mem_ready = 1'b1;
      smp();
      tick();
      mem_ready = 1'b0;
      smp();
      check("s5_resp_mem_req", mem_req, 0);
      rst = 1'b1; if_req = 1'b1; ls_req = 1'b1;
      #1;
      check("s5_rst_if_gnt", if_gnt, 0);
      check("s5_rst_ls_gnt", ls_gnt, 0);
      check("s5_rst_rvalid", {30'd0, if_rvalid, ls_rvalid}, 0);
      check("s5_rst_err", err, 0);
      check("s5_rst_mem_req", mem_req, 0);
      check("s5_rst_stall", stall_cnt, 0);
      check("s5_rst_mem_addr", mem_addr, 0);
      tick();
      rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
      smp();
      check("s5_late_rvalid", {30'd0, if_rvalid, ls_rvalid}, 0);
      check("s5_late_err", err, 0);
      check("s5_late_mem_req", mem_req, 0);
      tick();
      mem_rvalid = 1'b0; if_req = 1'b1; ls_req = 1'b1;
      if_addr = 32'h8000_0030; ls_addr = 32'h0000_3000;
      smp();
      check("s5_tie_if_gnt", if_gnt, 1);
      check("s5_tie_ls_gnt", ls_gnt, 0);
      sb_q.push_back('{1'b0, 32'h0000_1234, 1'b0});
      tick();
      if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b1;
      smp();
      check("s5_mem_addr", mem_addr, 32'h8000_0030);
      tick();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
      smp();
      tick();
      mem_rvalid = 1'b0;
      smp();
      check("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, is the number of RESP cycles without mem_rvalid before the transaction is aborted.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF, is the read data returned on timeout.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 if_req  in  1  instruction fetch request, held until if_gnt.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  one-cycle pulse when the fetch request is captured.
REQ-008 if_rvalid / if_rdata  out  1 / 32  fetch response pulse and data.
REQ-009 ls_req, ls_we  in  1 each  load/store request, held until ls_gnt; write enable.
REQ-010 ls_addr, ls_wdata, ls_wmask  in  32 / 32 / 4  load/store address, store data and byte mask.
REQ-011 ls_gnt, ls_rvalid  out  1 each  capture pulse; completion pulse (load data or store ack).
REQ-012 ls_rdata  out  32  load response data.
REQ-013 mem_req, mem_we  out  1 each  memory request; write enable.
REQ-014 mem_addr, mem_wdata, mem_wmask  out  32 / 32 / 4  memory address, data and mask.
REQ-015 mem_ready  in  1  memory accepts mem_req this cycle.
REQ-016 mem_rvalid / mem_rdata  in  1 / 32  memory response pulse and data.
REQ-017 err  out  1  one-cycle pulse on timeout abort.
REQ-018 stall_cnt  out  32  cycles with mem_req=1 and mem_ready=0, saturating.

Function
REQ-019 FSM states: IDLE, REQ, RESP. At most one transaction is outstanding.
REQ-020 IDLE: when any request is present, the arbiter selects one owner, latches its address, data, mask and we, pulses that owner's gnt combinationally in the same cycle, and moves to REQ.
REQ-021 Arbitration is round-robin. When both request, the owner not granted last wins. Only one gnt is asserted per cycle.
REQ-022 Fetch transactions drive mem_we=0 and mem_wmask=0.
REQ-023 REQ: mem_req=1 with the latched fields held stable. mem_ready=1 moves the FSM to RESP; otherwise it stays in REQ and stall_cnt increments.
REQ-024 RESP: mem_req=0. On mem_rvalid, the owner's rvalid pulses in the same cycle with rdata=mem_rdata, and the FSM returns to IDLE.
REQ-025 A request present in the cycle of a response completion is not granted until the following IDLE cycle.
REQ-026 Minimum latency: gnt at T, mem_req at T+1, owner rvalid at T+2 (mem_ready at T+1, mem_rvalid at T+2).
REQ-027 Timeout: a counter runs in RESP. At TIMEOUT_CYC cycles without mem_rvalid, the owner's rvalid pulses with rdata=ERR_DATA, err pulses, and the FSM returns to IDLE.
REQ-028 A mem_rvalid arriving in IDLE or REQ is ignored.
REQ-029 Non-owner rvalid and all gnt outputs are 0 outside the cases above. if_rdata and ls_rdata are 0 when their rvalid is 0.
REQ-030 stall_cnt saturates at 32'hFFFFFFFF.

Reset
REQ-031 rst=1 asynchronously sets: state=IDLE, last owner=LS (so IF wins the first tie), timeout counter=0, stall_cnt=0, and all latched fields=0.
REQ-032 During reset, all outputs are 0.
REQ-033 Reset during REQ or RESP aborts the transaction with no rvalid or err. A mem_rvalid arriving after reset is ignored.

Structure
REQ-034 The shared package mem_arb_pkg holds the state enum (IDLE/REQ/RESP), the owner enum (OWN_IF/OWN_LS) and the default ERR_DATA constant.
REQ-035 The timeout counter is a sub-module, mem_arb_timer (clear/enable/expired); everything else stays in mem_arbiter.

Verification
REQ-036 Scenario 1: if_req with if_addr=0x80000000, mem_ready=1, mem_rvalid next cycle with mem_rdata=0x00100073 -> if_gnt at T, mem_req at T+1, if_rvalid at T+2 with if_rdata=0x00100073.
REQ-037 Scenario 2: if_req and ls_req both asserted from reset -> IF granted first, LS granted second; with both held, grants alternate IF, LS, IF, LS.
REQ-038 Scenario 3: store with ls_addr=0x80000104, ls_wdata=0x12345678, ls_wmask=4'b0001, and mem_ready held low 3 cycles -> mem_req, mem_we=1 and the fields stay stable for 4 cycles; stall_cnt=3; ls_rvalid on the ack.
REQ-039 Scenario 4: load where mem_rvalid never arrives (TIMEOUT_CYC=16) -> ls_rvalid and err pulse 16 cycles after entering RESP, ls_rdata=0xDEADBEEF; the next request proceeds normally.
REQ-040 Scenario 5: rst asserted mid-RESP, then mem_rvalid -> no rvalid or err; outputs are 0; the FSM is in IDLE and the next if_req is granted.
